// File: rtl/sinc3_decim_ctrl_if.sv
// Decimated sample hand-off from the sinc3 sequencer to its consumer.
// Producer drives data/valid, consumer drives ready.
interface sinc3_decim_ctrl_if #(
  parameter int DW = 13
);
  logic signed [DW-1:0] sample_data;
  logic                 sample_valid;
  logic                 sample_ready;

  modport master (
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/sinc3_decim_ctrl.sv
// Sequencer for a single-bit sinc3 decimator: enable divider, settle
// discard, every-OSR capture and valid/ready hand-off with overrun flag.
module sinc3_decim_ctrl #(
  parameter int OSR    = 16,
  parameter int DIV_W  = 8,
  parameter int SETTLE = 3,
  localparam int DW    = 3 * $clog2(OSR) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_W-1:0]     div,
  input  logic                 clr_ovr,
  output logic                 filt_en,
  input  logic signed [DW-1:0] filt_out,
  sinc3_decim_ctrl_if.master   smp,
  output logic                 overrun,
  output logic                 busy
);

  localparam int PW = $clog2(OSR);
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [PW-1:0] PLAST = PW'(OSR - 1);
  localparam logic [SW-1:0] SLAST =
    SW'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_l;
  logic [DIV_W-1:0] dcnt;
  logic [PW-1:0]    pcnt;
  logic [SW-1:0]    scnt;
  logic             cap_pending;
  logic             xfer;

  assign busy    = (state != S_IDLE);
  assign filt_en = busy && (dcnt == div_l);
  assign xfer    = smp.sample_valid && smp.sample_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      div_l            <= '0;
      dcnt             <= '0;
      pcnt             <= '0;
      scnt             <= '0;
      cap_pending      <= 1'b0;
      smp.sample_data  <= '0;
      smp.sample_valid <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      if (busy)
        dcnt <= (dcnt == div_l) ? '0 : dcnt + 1'b1;
      if (filt_en)
        pcnt <= (pcnt == PLAST) ? '0 : pcnt + 1'b1;
      // filter output lands on the enable edge, so grab it a cycle later
      cap_pending <= filt_en && (pcnt == PLAST) && !stop;

      unique case (1'b1)
        cap_pending && (state == S_SETTLE): begin
          scnt <= scnt + 1'b1;
          if (scnt == SLAST)
            state <= S_RUN;
          if (xfer)
            smp.sample_valid <= 1'b0;
          if (clr_ovr)
            overrun <= 1'b0;
        end
        cap_pending && (state == S_RUN): begin
          smp.sample_data  <= filt_out;
          smp.sample_valid <= 1'b1;
          if (smp.sample_valid && !smp.sample_ready)
            overrun <= 1'b1;
          else if (clr_ovr)
            overrun <= 1'b0;
        end
        default: begin
          if (xfer)
            smp.sample_valid <= 1'b0;
          if (clr_ovr)
            overrun <= 1'b0;
        end
      endcase

      if (stop) begin
        state <= S_IDLE;
      end else if (start && (state == S_IDLE)) begin
        div_l   <= div;
        dcnt    <= '0;
        pcnt    <= '0;
        scnt    <= '0;
        overrun <= 1'b0;
        state   <= (SETTLE == 0) ? S_RUN : S_SETTLE;
      end
    end
  end

endmodule
